// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
// wb_arbiter: write-back arbiter with destination-register scoreboard.
//
// Three execution units (bit0 ALU, bit1 FPU, bit2 MEM) compete for one
// register-file write port. A round-robin pointer picks the winner. The
// winning request is registered onto the write port one cycle later.
// A 64-entry pending scoreboard, indexed by {fmode, reg}, tracks issued
// destinations that have not yet been written back. It answers the issue
// check and two operand busy queries.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/fmode/reg/data   per-requester write-back request
//   req_ready                  per-requester grant (combinational, one-hot or zero)
//   wb_hold                    suppresses all grants while high
//   wenable/wfmode/wreg/wdata  registered register-file write port
//   iss_valid/fmode/reg        issue request marking a destination pending
//   iss_ready                  issue accepted (combinational)
//   q_fmode/q_reg              two operand queries
//   q_busy                     per-query pending flag (combinational)
module wb_arbiter #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        req_valid,
    input  logic [2:0]        req_fmode,
    input  logic [14:0]       req_reg,
    input  logic [3*DW-1:0]   req_data,
    output logic [2:0]        req_ready,
    input  logic              wb_hold,
    output logic              wenable,
    output logic              wfmode,
    output logic [4:0]        wreg,
    output logic [DW-1:0]     wdata,
    input  logic              iss_valid,
    input  logic              iss_fmode,
    input  logic [4:0]        iss_reg,
    output logic              iss_ready,
    input  logic [1:0]        q_fmode,
    input  logic [9:0]        q_reg,
    output logic [1:0]        q_busy
);

    // Requester index reached by stepping 'off' places past 'ptr', modulo 3.
    function automatic logic [1:0] rr_index(input logic [1:0] ptr, input logic [1:0] off);
        logic [2:0] sum;
        logic [2:0] wrapped;
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= 3'd3) begin
            wrapped = sum - 3'd3;
        end else begin
            wrapped = sum;
        end
        return wrapped[1:0];
    endfunction

    logic [1:0]    rr_ptr_r;
    logic          wenable_r;
    logic          wfmode_r;
    logic [4:0]    wreg_r;
    logic [DW-1:0] wdata_r;
    logic [63:0]   pending_r;

    logic [1:0]    cand_s;
    logic          grant_any_s;
    logic [1:0]    grant_idx_s;
    logic [2:0]    grant_s;
    logic          sel_fmode_s;
    logic [4:0]    sel_reg_s;
    logic [DW-1:0] sel_data_s;
    logic          write_s;

    logic [5:0]    iss_idx_s;
    logic          iss_zero_s;
    logic          iss_ready_s;
    logic          iss_fire_s;
    logic [63:0]   pending_next_s;
    logic [5:0]    q_idx0_s;
    logic [5:0]    q_idx1_s;

    assign wenable   = wenable_r;
    assign wfmode    = wfmode_r;
    assign wreg      = wreg_r;
    assign wdata     = wdata_r;
    assign req_ready = grant_s;
    assign iss_ready = iss_ready_s;

    // Round-robin search from rr_ptr; grants are forced off in reset and hold.
    always_comb begin
        cand_s      = 2'd0;
        grant_any_s = 1'b0;
        grant_idx_s = 2'd0;
        grant_s     = 3'b000;
        if (rstn && !wb_hold) begin
            for (int off = 0; off < 3; off++) begin
                cand_s = rr_index(rr_ptr_r, 2'(off));
                if (!grant_any_s && req_valid[cand_s]) begin
                    grant_any_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
            if (grant_any_s) begin
                grant_s = 3'b001 << grant_idx_s;
            end else begin
                grant_s = 3'b000;
            end
        end else begin
            grant_s = 3'b000;
        end
    end

    // Route the winning requester's fields toward the write port.
    always_comb begin
        sel_fmode_s = 1'b0;
        sel_reg_s   = 5'd0;
        sel_data_s  = {DW{1'b0}};
        case (grant_idx_s)
            2'd0: begin
                sel_fmode_s = req_fmode[0];
                sel_reg_s   = req_reg[4:0];
                sel_data_s  = req_data[DW-1:0];
            end
            2'd1: begin
                sel_fmode_s = req_fmode[1];
                sel_reg_s   = req_reg[9:5];
                sel_data_s  = req_data[2*DW-1:DW];
            end
            2'd2: begin
                sel_fmode_s = req_fmode[2];
                sel_reg_s   = req_reg[14:10];
                sel_data_s  = req_data[3*DW-1:2*DW];
            end
            default: begin
                sel_fmode_s = 1'b0;
                sel_reg_s   = 5'd0;
                sel_data_s  = {DW{1'b0}};
            end
        endcase
    end

    // Integer r0 is hard-wired zero: the handshake completes but nothing is written.
    assign write_s = grant_any_s & ~(~sel_fmode_s & (sel_reg_s == 5'd0));

    // Write port and round-robin pointer. Data fields only move on a real write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wenable_r <= 1'b0;
            wfmode_r  <= 1'b0;
            wreg_r    <= 5'd0;
            wdata_r   <= {DW{1'b0}};
            rr_ptr_r  <= 2'd0;
        end else begin
            wenable_r <= write_s;
            if (write_s) begin
                wfmode_r <= sel_fmode_s;
                wreg_r   <= sel_reg_s;
                wdata_r  <= sel_data_s;
            end else begin
                wfmode_r <= wfmode_r;
                wreg_r   <= wreg_r;
                wdata_r  <= wdata_r;
            end
            if (grant_any_s) begin
                rr_ptr_r <= rr_index(grant_idx_s, 2'd1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign iss_idx_s   = {iss_fmode, iss_reg};
    assign iss_zero_s  = ~iss_fmode & (iss_reg == 5'd0);
    assign iss_ready_s = rstn & (iss_zero_s | ~pending_r[iss_idx_s]);
    assign iss_fire_s  = iss_valid & iss_ready_s & ~iss_zero_s;

    // Scoreboard update: clear is applied first so a same-cycle set wins.
    always_comb begin
        pending_next_s = pending_r;
        if (wenable_r) begin
            pending_next_s[{wfmode_r, wreg_r}] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (iss_fire_s) begin
            pending_next_s[iss_idx_s] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_r <= 64'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign q_idx0_s = {q_fmode[0], q_reg[4:0]};
    assign q_idx1_s = {q_fmode[1], q_reg[9:5]};

    // Operand busy lookups; integer r0 always reads as free.
    always_comb begin
        q_busy = 2'b00;
        if (q_idx0_s == 6'd0) begin
            q_busy[0] = 1'b0;
        end else begin
            q_busy[0] = pending_r[q_idx0_s];
        end
        if (q_idx1_s == 6'd0) begin
            q_busy[1] = 1'b0;
        end else begin
            q_busy[1] = pending_r[q_idx1_s];
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_wb_arbiter;

    localparam int DW = 32;

    logic            clk;
    logic            rstn;
    logic [2:0]      req_valid;
    logic [2:0]      req_fmode;
    logic [14:0]     req_reg;
    logic [3*DW-1:0] req_data;
    logic [2:0]      req_ready;
    logic            wb_hold;
    logic            wenable;
    logic            wfmode;
    logic [4:0]      wreg;
    logic [DW-1:0]   wdata;
    logic            iss_valid;
    logic            iss_fmode;
    logic [4:0]      iss_reg;
    logic            iss_ready;
    logic [1:0]      q_fmode;
    logic [9:0]      q_reg;
    logic [1:0]      q_busy;

    int checks_cnt;
    int errors_cnt;

    wb_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_fmode (req_fmode),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_hold   (wb_hold),
        .wenable   (wenable),
        .wfmode    (wfmode),
        .wreg      (wreg),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_fmode (iss_fmode),
        .iss_reg   (iss_reg),
        .iss_ready (iss_ready),
        .q_fmode   (q_fmode),
        .q_reg     (q_reg),
        .q_busy    (q_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic fm, input logic [4:0] rg, input logic [DW-1:0] dt);
        req_fmode[i]        = fm;
        req_reg[5*i +: 5]   = rg;
        req_data[DW*i +: DW] = dt;
    endtask

    initial begin
        logic [2:0]    exp_rdy;
        logic [4:0]    exp_reg;
        logic [DW-1:0] exp_dat;
        checks_cnt = 0;
        errors_cnt = 0;
        rstn      = 1'b0;
        req_valid = 3'b111;
        req_fmode = 3'b000;
        req_reg   = 15'd0;
        req_data  = '0;
        wb_hold   = 1'b0;
        iss_valid = 1'b1;
        iss_fmode = 1'b0;
        iss_reg   = 5'd5;
        q_fmode   = 2'b00;
        q_reg     = 10'd0;
        #2;
        check_val("rst_wenable", 64'(wenable), 64'd0);
        check_val("rst_wfmode", 64'(wfmode), 64'd0);
        check_val("rst_wreg", 64'(wreg), 64'd0);
        check_val("rst_wdata", 64'(wdata), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        check_val("rst_iss_ready", 64'(iss_ready), 64'd0);
        tick();
        tick();
        iss_valid = 1'b0;
        rstn = 1'b1;

        // Round-robin rotation with all three valid.
        set_req(0, 1'b0, 5'd1, 32'h0000_00A0);
        set_req(1, 1'b0, 5'd2, 32'h0000_00B0);
        set_req(2, 1'b0, 5'd3, 32'h0000_00C0);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = 3'b001 << (i % 3);
            check_val("rr_ready", 64'(req_ready), 64'(exp_rdy));
            tick();
            exp_reg = 5'((i % 3) + 1);
            exp_dat = 32'h0000_00A0 + 32'((i % 3) * 16);
            check_val("rr_wenable", 64'(wenable), 64'd1);
            check_val("rr_wreg", 64'(wreg), 64'(exp_reg));
            check_val("rr_wdata", 64'(wdata), 64'(exp_dat));
        end
        req_valid = 3'b000;
        tick();
        check_val("rr_idle_wenable", 64'(wenable), 64'd0);

        // Issue int r5, then float f5, then a blocked second int r5.
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd5;
        #1;
        check_val("iss_r5_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        q_fmode = 2'b10; q_reg = {5'd5, 5'd5};
        #1;
        check_val("busy_r5_only", 64'(q_busy), 64'b01);
        iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd5;
        #1;
        check_val("iss_f5_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check_val("busy_r5_f5", 64'(q_busy), 64'b11);
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd5;
        #1;
        check_val("iss_r5_again", 64'(iss_ready), 64'd0);
        iss_valid = 1'b0;

        // ALU writes back r5.
        set_req(0, 1'b0, 5'd5, 32'h0000_1234);
        req_valid = 3'b001;
        #1;
        check_val("wb_r5_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        check_val("wb_r5_wenable", 64'(wenable), 64'd1);
        check_val("wb_r5_wreg", 64'(wreg), 64'd5);
        check_val("wb_r5_wdata", 64'(wdata), 64'h1234);
        check_val("wb_r5_wfmode", 64'(wfmode), 64'd0);
        check_val("wb_r5_busy_during", 64'(q_busy), 64'b11);
        tick();
        check_val("wb_r5_wen_off", 64'(wenable), 64'd0);
        check_val("wb_r5_wreg_hold", 64'(wreg), 64'd5);
        check_val("wb_r5_busy_after", 64'(q_busy), 64'b10);

        // FPU writes integer r0: handshake but no write.
        set_req(1, 1'b0, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b010;
        #1;
        check_val("r0_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        check_val("r0_wenable", 64'(wenable), 64'd0);
        check_val("r0_wdata_hold", 64'(wdata), 64'h1234);
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd0;
        q_fmode = 2'b00; q_reg = 10'd0;
        #1;
        check_val("r0_iss_ready", 64'(iss_ready), 64'd1);
        check_val("r0_busy", 64'(q_busy), 64'b00);
        tick();
        iss_valid = 1'b0;
        #1;
        check_val("r0_busy_after", 64'(q_busy), 64'b00);

        // Write-back to non-pending r6 while r6 is issued: set wins.
        set_req(0, 1'b0, 5'd6, 32'h0000_0066);
        req_valid = 3'b001;
        #1;
        check_val("r6_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        check_val("r6_wenable", 64'(wenable), 64'd1);
        check_val("r6_wreg", 64'(wreg), 64'd6);
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd6;
        #1;
        check_val("r6_iss_ready", 64'(iss_ready), 64'd1);
        tick();
        iss_valid = 1'b0;
        q_fmode = 2'b00; q_reg = {5'd0, 5'd6};
        #1;
        check_val("r6_set_wins", 64'(q_busy), 64'b01);

        // Issue f9, then hold with all valid (rr_ptr now at FPU).
        iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd9;
        tick();
        iss_valid = 1'b0;
        set_req(1, 1'b1, 5'd7, 32'h0000_0077);
        wb_hold = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("hold_ready", 64'(req_ready), 64'd0);
            tick();
            check_val("hold_wenable", 64'(wenable), 64'd0);
        end
        wb_hold = 1'b0;
        #1;
        check_val("release_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        check_val("release_wenable", 64'(wenable), 64'd1);
        check_val("release_wfmode", 64'(wfmode), 64'd1);
        check_val("release_wreg", 64'(wreg), 64'd7);
        check_val("release_wdata", 64'(wdata), 64'h77);

        // Reset mid-operation right after that handshake.
        rstn = 1'b0;
        #1;
        check_val("midrst_wenable", 64'(wenable), 64'd0);
        check_val("midrst_wdata", 64'(wdata), 64'd0);
        check_val("midrst_wreg", 64'(wreg), 64'd0);
        req_valid = 3'b111;
        iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd6;
        #1;
        check_val("midrst_req_ready", 64'(req_ready), 64'd0);
        check_val("midrst_iss_ready", 64'(iss_ready), 64'd0);
        tick();
        rstn = 1'b1;
        iss_valid = 1'b0;
        req_valid = 3'b000;
        q_fmode = 2'b10; q_reg = {5'd9, 5'd6};
        #1;
        check_val("postrst_busy", 64'(q_busy), 64'b00);
        req_valid = 3'b111;
        #1;
        check_val("postrst_rr_ptr", 64'(req_ready), 64'b001);
        req_valid = 3'b000;
        tick();
        check_val("postrst_no_pulse", 64'(wenable), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
